// File: rtl/rv_pkg.sv
// rv_pkg: shared RV32I opcode constants, immediate-format enum and opcode-to-format mapping.
//   XLEN        datapath width (32 only)
//   OPC_*       7-bit major opcodes recognised by the ID stage
//   fmt_e       immediate encoding selected by an opcode
//   opc_fmt()   opcode -> fmt_e, FMT_BAD for anything unrecognised
package rv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD} fmt_e;

    function automatic fmt_e opc_fmt(input logic [6:0] opc);
        return (opc == OPC_OPIMM || opc == OPC_LOAD || opc == OPC_JALR) ? FMT_I :
               (opc == OPC_STORE)                                       ? FMT_S :
               (opc == OPC_BRANCH)                                      ? FMT_B :
               (opc == OPC_LUI || opc == OPC_AUIPC)                     ? FMT_U :
               (opc == OPC_JAL)                                         ? FMT_J :
               (opc == OPC_OP)                                          ? FMT_R : FMT_BAD;
    endfunction

endpackage

// File: rtl/imm_decode.sv
// imm_decode: combinational RV32I immediate extraction and operand-B select.
//   inst     in  32  instruction word
//   imm      out 32  sign/zero-extended immediate (0 for R-type and unknown opcodes)
//   alusrc   out 1   1 = EX operand B takes the immediate
//   illegal  out 1   opcode not recognised
module imm_decode import rv_pkg::*; #(
    parameter bit SHAMT_ZEXT = 1'b1
) (
    input  logic [31:0] inst,
    output logic [31:0] imm,
    output logic        alusrc,
    output logic        illegal
);

    fmt_e fmt;
    logic shamt;

    always_comb begin
        fmt     = opc_fmt(inst[6:0]);
        // slli/srli/srai carry funct7 in inst[31:25]; only the shift amount is the operand
        shamt   = SHAMT_ZEXT && inst[6:0] == OPC_OPIMM && (inst[14:12] == 3'b001 || inst[14:12] == 3'b101);
        imm     = (fmt == FMT_I) ? (shamt ? {27'b0, inst[24:20]} : {{20{inst[31]}}, inst[31:20]}) :
                  (fmt == FMT_S) ? {{20{inst[31]}}, inst[31:25], inst[11:7]} :
                  (fmt == FMT_B) ? {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0} :
                  (fmt == FMT_U) ? {inst[31:12], 12'b0} :
                  (fmt == FMT_J) ? {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0} : 32'b0;
        alusrc  = fmt == FMT_I || fmt == FMT_S || fmt == FMT_U || fmt == FMT_J;
        illegal = fmt == FMT_BAD;
    end

endmodule

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: ID->EX register stage producing IMM_full/RS2_full/ALUsrc behind a 2-entry skid buffer.
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    upstream handshake; in_ready is registered
//   inst, rs2_data       instruction word and RS2 read data
//   flush                synchronous kill of all buffered entries
//   out_valid/out_ready  downstream handshake
//   ALUsrc, IMM_full, RS2_full, illegal   registered decode results of the head entry
module imm_gen_stage import rv_pkg::*; #(
    parameter int XLEN       = 32,
    parameter bit SHAMT_ZEXT = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] inst,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            ALUsrc,
    output logic [XLEN-1:0] IMM_full,
    output logic [XLEN-1:0] RS2_full,
    output logic            illegal
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

    state_e          state, state_nx;
    logic [XLEN-1:0] d_imm, s_imm, s_rs2;
    logic            d_src, d_ill, s_src, s_ill;
    logic            in_xfer, out_xfer, ld_main_in, ld_main_skid, ld_skid;

    imm_decode #(.SHAMT_ZEXT(SHAMT_ZEXT)) u_dec (
        .inst    (inst),
        .imm     (d_imm),
        .alusrc  (d_src),
        .illegal (d_ill)
    );

    assign out_valid = state != EMPTY;

    always_comb begin
        in_xfer      = in_valid & in_ready;
        out_xfer     = out_valid & out_ready;
        state_nx     = state;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        case (state)
            EMPTY: begin
                state_nx   = in_xfer ? ONE : EMPTY;
                ld_main_in = in_xfer;
            end
            ONE: begin
                state_nx   = (in_xfer && !out_xfer) ? TWO : (!in_xfer && out_xfer) ? EMPTY : ONE;
                ld_main_in = in_xfer && out_xfer;
                ld_skid    = in_xfer && !out_xfer;
            end
            TWO: begin
                state_nx     = out_xfer ? ONE : TWO;
                ld_main_skid = out_xfer;
            end
            default: state_nx = EMPTY;
        endcase
        if (flush) begin
            state_nx     = EMPTY;
            ld_main_in   = 1'b0;
            ld_main_skid = 1'b0;
            ld_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
            ALUsrc   <= 1'b0;
            illegal  <= 1'b0;
            IMM_full <= '0;
            RS2_full <= '0;
            s_src    <= 1'b0;
            s_ill    <= 1'b0;
            s_imm    <= '0;
            s_rs2    <= '0;
        end else begin
            state    <= state_nx;
            in_ready <= state_nx != TWO;
            if (ld_main_in) begin
                ALUsrc   <= d_src;
                illegal  <= d_ill;
                IMM_full <= d_imm;
                RS2_full <= rs2_data;
            end else if (ld_main_skid) begin
                ALUsrc   <= s_src;
                illegal  <= s_ill;
                IMM_full <= s_imm;
                RS2_full <= s_rs2;
            end else if (flush) begin
                // data words may go stale, but control bits must not suggest a live entry
                ALUsrc  <= 1'b0;
                illegal <= 1'b0;
            end
            if (ld_skid) begin
                s_src <= d_src;
                s_ill <= d_ill;
                s_imm <= d_imm;
                s_rs2 <= rs2_data;
            end
        end
    end

endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage: directed and randomized checks of imm_gen_stage against a queue-based reference model.
module tb_imm_gen_stage;

    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [31:0] inst = '0, rs2_data = '0;
    logic        in_ready, out_valid, ALUsrc, illegal;
    logic [31:0] IMM_full, RS2_full;

    imm_gen_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inst      (inst),
        .rs2_data  (rs2_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALUsrc    (ALUsrc),
        .IMM_full  (IMM_full),
        .RS2_full  (RS2_full),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] imm;
        logic [31:0] rs2;
        logic        src;
        logic        ill;
    } ent_t;

    ent_t q[$];
    bit   exp_clr;
    int   n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // immediate value rebuilt from field weights rather than bit concatenation
    function automatic ent_t ref_dec(input logic [31:0] i, input logic [31:0] r);
        ent_t e;
        int   v;
        v     = 0;
        e.rs2 = r;
        e.src = 1'b1;
        e.ill = 1'b0;
        case (i[6:0])
            7'h13:        v = (i[13:12] == 2'b01) ? int'(i[24:20]) : int'($signed(i[31:20]));
            7'h03, 7'h67: v = int'($signed(i[31:20]));
            7'h23:        v = int'($signed({i[31:25], i[11:7]}));
            7'h63: begin
                v = (i[31] ? -4096 : 0) + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
                e.src = 1'b0;
            end
            7'h37, 7'h17: v = int'(i[31:12]) * 4096;
            7'h6F:        v = (i[31] ? -(1 << 20) : 0) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
            7'h33: begin
                v = 0;
                e.src = 1'b0;
            end
            default: begin
                v = 0;
                e.src = 1'b0;
                e.ill = 1'b1;
            end
        endcase
        e.imm = v;
        return e;
    endfunction

    // drive one cycle from a negedge, advance the model, then check at the next negedge
    task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] r,
                        input logic ordy, input logic fl);
        bit ix, ox;
        in_valid  = iv;
        inst      = ins;
        rs2_data  = r;
        out_ready = ordy;
        flush     = fl;
        ix = iv && q.size() < 2;
        ox = ordy && q.size() > 0;
        exp_clr = fl;
        if (fl) q.delete();
        else begin
            if (ox) void'(q.pop_front());
            if (ix) q.push_back(ref_dec(ins, r));
        end
        @(negedge clk);
        chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
        chk("in_ready", {31'b0, in_ready}, {31'b0, q.size() < 2});
        if (q.size() > 0) begin
            chk("IMM_full", IMM_full, q[0].imm);
            chk("RS2_full", RS2_full, q[0].rs2);
            chk("ALUsrc", {31'b0, ALUsrc}, {31'b0, q[0].src});
            chk("illegal", {31'b0, illegal}, {31'b0, q[0].ill});
        end
        if (exp_clr) begin
            chk("flush_ALUsrc", {31'b0, ALUsrc}, 32'd0);
            chk("flush_illegal", {31'b0, illegal}, 32'd0);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_ALUsrc", {31'b0, ALUsrc}, 32'd0);
        chk("rst_illegal", {31'b0, illegal}, 32'd0);
        chk("rst_IMM_full", IMM_full, 32'd0);
        chk("rst_RS2_full", RS2_full, 32'd0);
    endtask

    logic [6:0] opcs [12] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F, 7'h00, 7'h73};

    initial begin
        repeat (2) @(negedge clk);
        chk_reset_vals();
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_vals();

        step(1, 32'hFFF00093, 32'h0, 1, 0);
        chk("addi_imm", IMM_full, 32'hFFFFFFFF);
        chk("addi_src", {31'b0, ALUsrc}, 32'd1);
        step(1, 32'h0020A423, 32'hDEADBEEF, 1, 0);
        chk("sw_imm", IMM_full, 32'h00000008);
        chk("sw_rs2", RS2_full, 32'hDEADBEEF);
        step(1, 32'hFE000EE3, 32'h1, 1, 0);
        chk("beq_imm", IMM_full, 32'hFFFFFFFC);
        chk("beq_src", {31'b0, ALUsrc}, 32'd0);
        step(1, 32'h123452B7, 32'h2, 1, 0);
        chk("lui_imm", IMM_full, 32'h12345000);
        chk("lui_src", {31'b0, ALUsrc}, 32'd1);
        step(0, 32'h0, 32'h0, 1, 0);

        step(1, 32'h00500093, 32'hA1, 0, 0);
        step(1, 32'h00A00093, 32'hA2, 0, 0);
        chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
        chk("bp_hold_imm", IMM_full, 32'd5);
        step(1, 32'h00F00093, 32'hA3, 0, 0);
        chk("bp_hold_imm2", IMM_full, 32'd5);
        step(1, 32'h00F00093, 32'hA3, 1, 0);
        chk("bp_drain2", IMM_full, 32'd10);
        step(1, 32'h00F00093, 32'hA3, 1, 0);
        chk("bp_drain3", IMM_full, 32'd15);
        chk("bp_drain3_rs2", RS2_full, 32'hA3);
        step(0, 32'h0, 32'h0, 1, 0);

        step(1, 32'h0000007F, 32'h0, 1, 0);
        chk("ill_flag", {31'b0, illegal}, 32'd1);
        chk("ill_imm", IMM_full, 32'd0);
        chk("ill_valid", {31'b0, out_valid}, 32'd1);
        step(1, 32'h0000007F, 32'h1, 0, 0);
        step(1, 32'hFFF00093, 32'h2, 0, 1);
        chk("fl_out_valid", {31'b0, out_valid}, 32'd0);
        chk("fl_in_ready", {31'b0, in_ready}, 32'd1);
        step(1, 32'hFFF00093, 32'h3, 0, 0);
        step(1, 32'h123452B7, 32'h4, 0, 0);
        step(0, 32'h0, 32'h0, 0, 1);

        for (int n = 0; n < 3000; n++) begin
            logic [31:0] w;
            w = $urandom;
            w[6:0] = opcs[$urandom_range(0, 11)];
            step($urandom_range(0, 3) != 0, w, $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0);
        end

        step(1, 32'h123452B7, 32'h5, 0, 0);
        step(1, 32'h0020A423, 32'h6, 0, 0);
        #3 rst_n = 1'b0;
        #1 chk_reset_vals();
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 32'h0, 32'h0, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
- ID->EX boundary stage. It is the producer of the ALU operand-B select and the immediate operand.
- Accepts a decoded-slot instruction word plus RS2 register data over a valid/ready handshake.
- Extracts and sign-extends the RV32I immediate and derives ALUsrc.
- Presents IMM_full, RS2_full and ALUsrc, registered, to the EX-stage operand-B multiplexer.
- A 2-entry skid buffer gives registered in_ready and full throughput under backpressure.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- SHAMT_ZEXT, 1, when 1, OP-IMM shifts (funct3 001/101) output zero-extended inst[24:20]; when 0, plain I-type extension.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream holds instruction/RS2 valid
- in_ready  output  1  stage can accept; registered
- inst  input  32  instruction word
- rs2_data  input  32  RS2 register-file read data
- flush  input  1  synchronous pipeline kill
- out_valid  output  1  outputs below are valid
- out_ready  input  1  EX stage consumes this cycle
- ALUsrc  output  1  1 = EX operand B takes IMM_full
- IMM_full  output  32  sign/zero-extended immediate
- RS2_full  output  32  registered rs2_data
- illegal  output  1  opcode not recognised

Behaviour:
- Reset (rst_n low, async): state EMPTY, in_ready=1, out_valid=0, ALUsrc=0, IMM_full=0, RS2_full=0, illegal=0.
- Transfers: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
- Decode (combinational on inst, result captured at input transfer), keyed on opcode inst[6:0]:
  - 0010011 OP-IMM, 0000011 LOAD, 1100111 JALR: I-type {{20{i[31]}},i[31:20]}, ALUsrc=1.
  - 0100011 STORE: S-type {{20{i[31]}},i[31:25],i[11:7]}, ALUsrc=1.
  - 1100011 BRANCH: B-type {{19{i[31]}},i[31],i[7],i[30:25],i[11:8],1'b0}, ALUsrc=0.
  - 0110111 LUI, 0010111 AUIPC: U-type {i[31:12],12'b0}, ALUsrc=1.
  - 1101111 JAL: J-type {{11{i[31]}},i[31],i[19:12],i[20],i[30:21],1'b0}, ALUsrc=1.
  - 0110011 OP: IMM=0, ALUsrc=0.
  - Any other opcode: IMM=0, ALUsrc=0, illegal=1. The entry still flows through the stage; trapping is downstream's job.
- Storage: main entry drives the outputs; skid entry holds overflow.
- FSM states and transitions:
  - EMPTY: in_ready=1. An input transfer loads main and goes to ONE.
  - ONE: in_ready=1.
    - Input and output together: reload main, stay ONE.
    - Input only: load skid, go TWO.
    - Output only: go EMPTY.
  - TWO: in_ready=0. An output transfer moves skid to main and goes to ONE. Input is not accepted.
- in_ready is a flop: 0 only in TWO.
- Latency: 1 cycle from input transfer to out_valid when empty. Throughput is 1 per cycle when out_ready stays high.
- Output stability: while out_valid=1 and out_ready=0, all outputs hold stable.
- flush: next state EMPTY; out_valid=0 the next cycle. Any same-cycle input transfer is discarded. Data registers may keep stale values, but ALUsrc/illegal are cleared.
- Reset mid-operation: immediately returns to the reset values; buffered entries are lost.

Decomposition:
- Shared package rv_pkg holds:
  - opcode localparams: OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC;
  - immediate-format enum {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD};
  - XLEN.
- One natural sub-module: imm_decode, purely combinational, mapping inst to {IMM, ALUsrc, illegal}.
- The skid buffer/FSM stays in imm_gen_stage.

Test Plan:
- addi x1,x0,-1 (0xFFF00093), out_ready=1 -> next cycle out_valid=1, IMM_full=0xFFFFFFFF, ALUsrc=1, illegal=0.
- sw x2,8(x1) (0x0020A423), rs2_data=0xDEADBEEF -> IMM_full=0x00000008, ALUsrc=1, RS2_full=0xDEADBEEF.
- beq x0,x0,-4 (0xFE000EE3) then lui x5,0x12345 (0x123452B7) back-to-back:
  - beq -> IMM_full=0xFFFFFFFC, ALUsrc=0;
  - lui -> IMM_full=0x12345000, ALUsrc=1;
  - one result per cycle.
- Backpressure: out_ready=0, push 3 instructions -> in_ready drops after the 2nd accept. Outputs hold the 1st. Release out_ready -> entries drain in order, none lost or duplicated.
- Illegal 0x0000007F -> illegal=1, IMM_full=0, ALUsrc=0, out_valid=1.
- flush in TWO with in_valid=1 -> next cycle out_valid=0, in_ready=1, state EMPTY. Assert rst_n=0 mid-stream -> outputs at reset values immediately, not at a clock edge.
